// File: rtl/universal_shift_register_4b.sv
// 4-bit universal register: SISO / SIPO / PISO / PIPO selected by mode.
// Optional feature macro UREG_PISO_ROTATE_EN: PISO shift recirculates MSB instead of zero-filling.
module universal_shift_register_4b (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] mode,
    input  logic       load,
    input  logic       siso_in,
    input  logic [3:0] parallel_in,
    output logic       siso_out,
    output logic [3:0] parallel_out,
    output logic [3:0] pipo_out,
    output logic [3:0] reg_data
);

    localparam logic [1:0] MODE_SISO = 2'b00;
    localparam logic [1:0] MODE_SIPO = 2'b01;
    localparam logic [1:0] MODE_PISO = 2'b10;
    localparam logic [1:0] MODE_PIPO = 2'b11;

    logic [3:0] r_q;
    logic [3:0] r_d;
    logic       piso_fill_s;

`ifdef UREG_PISO_ROTATE_EN
    assign piso_fill_s = r_q[3];
`else
    assign piso_fill_s = 1'b0;
`endif

    // Next-state selection: hold when disabled, otherwise the mode action.
    always_comb begin
        r_d = r_q;
        if (!enable) begin
            r_d = r_q;
        end else begin
            case (mode)
                MODE_SISO: r_d = {r_q[2:0], siso_in};
                MODE_SIPO: r_d = {r_q[2:0], siso_in};
                MODE_PISO: begin
                    if (load) begin
                        r_d = parallel_in;
                    end else begin
                        r_d = {r_q[2:0], piso_fill_s};
                    end
                end
                MODE_PIPO: begin
                    if (load) begin
                        r_d = parallel_in;
                    end else begin
                        r_d = r_q;
                    end
                end
                default: r_d = r_q;
            endcase
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= 4'b0000;
        end else begin
            r_q <= r_d;
        end
    end

    // Observation views are decoded straight from the register and current mode.
    always_comb begin
        siso_out     = r_q[3];
        reg_data     = r_q;
        parallel_out = 4'b0000;
        pipo_out     = 4'b0000;
        if (mode == MODE_SIPO) begin
            parallel_out = r_q;
        end else begin
            parallel_out = 4'b0000;
        end
        if (mode == MODE_PIPO) begin
            pipo_out = r_q;
        end else begin
            pipo_out = 4'b0000;
        end
    end

endmodule

// File: tb/tb_universal_shift_register_4b.sv
// Scoreboard bench for universal_shift_register_4b: directed test-plan sequences then random traffic.
module tb_universal_shift_register_4b;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [1:0] mode;
    logic       load;
    logic       siso_in;
    logic [3:0] parallel_in;
    logic       siso_out;
    logic [3:0] parallel_out;
    logic [3:0] pipo_out;
    logic [3:0] reg_data;

    universal_shift_register_4b dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .mode         (mode),
        .load         (load),
        .siso_in      (siso_in),
        .parallel_in  (parallel_in),
        .siso_out     (siso_out),
        .parallel_out (parallel_out),
        .pipo_out     (pipo_out),
        .reg_data     (reg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] reg_v;
        logic       siso_v;
        logic [3:0] par_v;
        logic [3:0] pipo_v;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_r     = 0;   // reference register contents as an integer 0..15

    // Expected observable outputs for the current model value under the given mode.
    task automatic push_exp(input logic [1:0] md, input string tag);
        exp_t e;
        e.tag    = tag;
        e.reg_v  = 4'(m_r);
        e.siso_v = (m_r >= 8);
        e.par_v  = (md == 2'd1) ? 4'(m_r) : 4'd0;
        e.pipo_v = (md == 2'd3) ? 4'(m_r) : 4'd0;
        exp_q.push_back(e);
    endtask

    // One cycle: drive inputs, record expectation for the pre-edge view, advance model at the edge.
    task automatic step(input logic r, input logic en, input logic [1:0] md, input logic ld,
                        input logic sin, input logic [3:0] pin, input string tag);
        rst = r; enable = en; mode = md; load = ld; siso_in = sin; parallel_in = pin;
        if (r) m_r = 0;
        push_exp(md, tag);
        @(posedge clk);
        if (!r && en) begin
            case (md)
                2'd0, 2'd1: m_r = (m_r * 2 + int'(sin)) % 16;
                2'd2: begin
                    if (ld) m_r = int'(pin);
`ifdef UREG_PISO_ROTATE_EN
                    else m_r = (m_r * 2 + m_r / 8) % 16;
`else
                    else m_r = (m_r * 2) % 16;
`endif
                end
                default: if (ld) m_r = int'(pin);
            endcase
        end
        #1;
    endtask

    // Monitor: every falling edge, compare the DUT view against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests += 4;
            if (reg_data !== e.reg_v) begin
                n_fail++;
                $display("FAIL %s reg_data: got %b expected %b", e.tag, reg_data, e.reg_v);
            end
            if (siso_out !== e.siso_v) begin
                n_fail++;
                $display("FAIL %s siso_out: got %b expected %b", e.tag, siso_out, e.siso_v);
            end
            if (parallel_out !== e.par_v) begin
                n_fail++;
                $display("FAIL %s parallel_out: got %b expected %b", e.tag, parallel_out, e.par_v);
            end
            if (pipo_out !== e.pipo_v) begin
                n_fail++;
                $display("FAIL %s pipo_out: got %b expected %b", e.tag, pipo_out, e.pipo_v);
            end
        end
    end

    initial begin
        rst = 1'b1; enable = 1'b1; mode = 2'd0; load = 1'b0; siso_in = 1'b0; parallel_in = 4'd0;
        @(posedge clk);
        #1;
        // Reset with random inputs, then SISO shift 1,0,1,1 and a 3-cycle hold.
        step(1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 4'hF, "reset");
        step(1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 4'h0, "siso0");
        step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 4'h0, "siso1");
        step(1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 4'h0, "siso2");
        step(1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 4'h0, "siso3");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 4'h5, "siso_hold");
        // SIPO shift 1,0,0,1, then view under mode 00.
        step(1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 4'h0, "sipo0");
        step(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 4'h0, "sipo1");
        step(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 4'h0, "sipo2");
        step(1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 4'h0, "sipo3");
        step(1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 4'h0, "sipo_view");
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'h0, "sipo_to_siso");
        // PISO load 1011 then 4 shifts, plus a repeated-load check.
        step(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 4'hB, "piso_load");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 4'h0, "piso_shift");
        step(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 4'h9, "piso_reload0");
        step(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 4'h9, "piso_reload1");
        step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 4'h0, "piso_after_reload");
        // PIPO load 1110, hold with load low, then blocked load under enable low.
        step(1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 4'hE, "pipo_load");
        step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 4'h0, "pipo_hold0");
        step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 4'h0, "pipo_hold1");
        step(1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 4'h3, "pipo_en_low");
        step(1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 4'h3, "pipo_en_low_chk");
        // Reset pulse mid-PISO shift clears immediately.
        step(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 4'hD, "piso2_load");
        step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 4'h0, "piso2_shift");
        step(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 4'h0, "rst_mid_piso");
        step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 4'h0, "after_rst");
        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), "random");
        end
        for (int i = 0; i < 8; i++) begin
            if (exp_q.size() != 0) @(negedge clk);
        end
        #1;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/universal_shift_register_4b.md
# universal_shift_register_4b

4-bit universal register (`top`) with four operating modes selected by `mode`:

- serial-in/serial-out (SISO)
- serial-in/parallel-out (SIPO)
- parallel-in/serial-out (PISO)
- parallel-in/parallel-out (PIPO)

It is a small datapath leaf block. It is clocked from the system clock and exposes its internal state on `reg_data` for debug and observation.

## Interface
Parameters: none; width is fixed at 4 bits.

- `clk`  input  1  rising-edge clock
- `rst`  input  1  asynchronous reset, active-high
- `enable`  input  1  clock enable; 0 = hold all state
- `mode`  input  2  00 SISO, 01 SIPO, 10 PISO, 11 PIPO
- `load`  input  1  parallel-load strobe; honoured only in modes 10/11
- `siso_in`  input  1  serial data in
- `parallel_in`  input  4  parallel data in
- `siso_out`  output  1  serial data out
- `parallel_out`  output  4  SIPO parallel view
- `pipo_out`  output  4  PIPO parallel view
- `reg_data`  output  4  internal register, always visible

## Operation
- Single internal 4-bit register R. `reg_data` = R.
- Update priority: `rst` > `enable` = 0 (hold) > mode action.
- Mode 00 (SISO):
  - R <= {R[2:0], siso_in}.
  - `load` is ignored.
- Mode 01 (SIPO): same shift as SISO. `load` is ignored.
- Mode 10 (PISO):
  - `load` = 1: R <= `parallel_in`.
  - `load` = 0: R <= {R[2:0], 1'b0}, shifting out MSB-first.
- Mode 11 (PIPO):
  - `load` = 1: R <= `parallel_in`.
  - `load` = 0: R holds.
- Outputs are combinational from R and `mode`:
  - `siso_out` = R[3] in every mode.
  - `parallel_out` = R when `mode` = 01, else 4'b0000.
  - `pipo_out` = R when `mode` = 11, else 4'b0000.
- Mode change does not clear R; the next mode operates on the current contents.

## Timing
- `rst` asserted: R = 0 immediately, without waiting for a clock edge.
  - Reset values: `siso_out` = 0, `parallel_out` = 0, `pipo_out` = 0, `reg_data` = 0.
  - Reset is held as long as `rst` = 1.
  - Deassertion is sampled cleanly: the first update is on the first rising edge with `rst` = 0.
- R updates on the rising `clk` edge. Outputs reflect the new R in the same cycle, with combinational delay only.
- Serial latency:
  - A bit presented on `siso_in` at edge n appears on `siso_out` after edge n+3.
  - That is 4 enabled edges, counting the capture edge.
- Parallel load: `parallel_in` sampled at the edge with `load` = 1 appears on `pipo_out` (mode 11) or `reg_data` right after that edge.
- `enable` = 0 freezes R regardless of `load`, `mode`, `siso_in`. Outputs still follow `mode` combinationally.
- `load` held high for several cycles in mode 10 reloads on every cycle, so no shifting occurs.
- `rst` asserted mid-shift or mid-load: R clears at once. The pending operation is discarded.

## Configuration
- Macro: `UREG_PISO_ROTATE_EN`.
- Defined: in mode 10 with `load` = 0, R <= {R[2:0], R[3]} (rotate), so the loaded word recirculates.
- Undefined (default): zero-fill shift as specified above.
- All other modes are unaffected by the macro.

## Test plan
- Reset: `rst` = 1 with random inputs -> all outputs 0, asynchronously. Release, then first enabled edge acts.
- SISO: `mode` = 00, `enable` = 1, shift in 1,0,1,1 -> `reg_data` = 4'b1011. `siso_out` shows the first 1 after the 4th edge. With `enable` = 0 for 3 cycles -> values unchanged.
- SIPO: `mode` = 01, shift 1,0,0,1 -> `parallel_out` = 4'b1001 and `pipo_out` = 0. Switching `mode` to 00 -> `parallel_out` = 0 and `reg_data` is still 1001.
- PISO: `mode` = 10, `load` = 1, `parallel_in` = 4'b1011 for one edge, then `load` = 0 for 4 edges:
  - `siso_out` sequence 1,0,1,1.
  - `reg_data` ends 0000, or 1011 with `UREG_PISO_ROTATE_EN`.
- PIPO: `mode` = 11, `load` = 1, `parallel_in` = 4'b1110 -> `pipo_out` = 4'b1110 after the edge. `load` = 0 and `parallel_in` = 0 for 2 edges -> still 1110.
- Priority/corner: `enable` = 0 with `load` = 1 in mode 11 -> no load. `rst` pulsed mid-PISO shift -> R = 0 immediately.
